// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill controller: fetches one block and writes data then tag.
// Optional CACHE_FILL_PERF_EN adds fill_count/fill_cycles performance counters.
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_detected,
  input  logic [ADDR_W-1:0]          miss_address,
  input  logic                       memory_data_valid,
  input  logic [15:0]                memory_data,
  output logic                       fsm_busy,
  output logic                       mem_read,
  output logic [ADDR_W-1:0]          memory_address,
  output logic                       write_data_array,
  output logic [$clog2(WORDS)-1:0]   word_offset,
  output logic [15:0]                data_array_wdata,
  output logic                       write_tag_array
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [15:0]                fill_count,
  output logic [15:0]                fill_cycles
`endif
);

  localparam int CW = $clog2(WORDS);
  localparam int OW = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]         state;
  logic [CW-1:0]      req_cnt;
  logic               req_done;
  logic [CW-1:0]      rcv_cnt;
  logic [ADDR_W-1:OW] base_hi;
  logic [ADDR_W-1:0]  addr_hold;
  logic [ADDR_W-1:0]  req_addr;
  logic               unused_bits;

  // req_done stands in for req_cnt==WORDS so the counter keeps its natural width
  assign unused_bits = ^miss_address[OW-1:0];
  assign req_addr    = {base_hi, req_cnt, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_cnt   <= '0;
      req_done  <= 1'b0;
      rcv_cnt   <= '0;
      base_hi   <= '0;
      addr_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base_hi  <= miss_address[ADDR_W-1:OW];
            req_cnt  <= '0;
            req_done <= 1'b0;
            rcv_cnt  <= '0;
            state    <= FILL;
          end
        end
        default: begin
          if (!req_done) begin
            addr_hold <= req_addr;
            if (req_cnt == LAST) req_done <= 1'b1;
            else                 req_cnt  <= req_cnt + 1'b1;
          end
          if (memory_data_valid) begin
            if (rcv_cnt == LAST) begin
              rcv_cnt <= '0;
              state   <= IDLE;
            end else begin
              rcv_cnt <= rcv_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    fsm_busy         = (state == FILL);
    mem_read         = fsm_busy && !req_done;
    memory_address   = mem_read ? req_addr : addr_hold;
    write_data_array = fsm_busy && memory_data_valid;
    word_offset      = rcv_cnt;
    data_array_wdata = write_data_array ? memory_data : 16'h0000;
    write_tag_array  = write_data_array && (rcv_cnt == LAST);
  end

`ifdef CACHE_FILL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_count  <= 16'h0000;
      fill_cycles <= 16'h0000;
    end else begin
      if (write_tag_array) fill_count <= fill_count + 16'h0001;
      if (fsm_busy && fill_cycles != 16'hFFFF) fill_cycles <= fill_cycles + 16'h0001;
    end
  end
`else
  // no performance counters in this build
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed bench for cache_fill_fsm with a 4-cycle pipelined memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic [15:0] data_array_wdata;
  logic        write_tag_array;
`ifdef CACHE_FILL_PERF_EN
  logic [15:0] fill_count;
  logic [15:0] fill_cycles;
`endif

  int checks = 0;
  int errors = 0;

  bit        hv [4];
  bit [15:0] ha [4];
  bit        model_v = 1'b0;
  bit [15:0] model_d = 16'h0000;
  bit        spur_v = 1'b0;
  bit [15:0] spur_d = 16'h0000;

  assign memory_data_valid = model_v | spur_v;
  assign memory_data       = model_v ? model_d : spur_d;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_offset       (word_offset),
    .data_array_wdata  (data_array_wdata),
    .write_tag_array   (write_tag_array)
`ifdef CACHE_FILL_PERF_EN
    ,
    .fill_count        (fill_count),
    .fill_cycles       (fill_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Memory answers a request seen in cycle k with a word in cycle k+4: data 0xA000 + word index.
  always @(posedge clk) begin
    #1;
    model_v = hv[3];
    model_d = 16'hA000 + {13'd0, ha[3][3:1]};
    for (int i = 3; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = (mem_read === 1'b1);
    ha[0] = memory_address;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(fsm_busy), 0);
    check({tag, "_rd"},    32'(mem_read), 0);
    check({tag, "_addr"},  32'(memory_address), 0);
    check({tag, "_wr"},    32'(write_data_array), 0);
    check({tag, "_off"},   32'(word_offset), 0);
    check({tag, "_wdata"}, 32'(data_array_wdata), 0);
    check({tag, "_tag"},   32'(write_tag_array), 0);
  endtask

  // Called in the cycle the miss is presented (cycle 0); checks cycles 1..13.
  task automatic run_fill(input logic [15:0] addr, input logic [15:0] exp_base,
                          input bit hold, input logic [15:0] next_addr);
    miss_detected = 1'b1;
    miss_address  = addr;
    for (int c = 1; c <= 13; c++) begin
      tick();
      check("busy", 32'(fsm_busy), 32'(c <= 12));
      check("mem_read", 32'(mem_read), 32'(c <= 8));
      if (c <= 8) check("req_addr", 32'(memory_address), 32'(exp_base) + 32'(2 * (c - 1)));
      else        check("addr_hold", 32'(memory_address), 32'(exp_base) + 32'h0E);
      check("wr_data", 32'(write_data_array), 32'(c >= 5 && c <= 12));
      if (c >= 5 && c <= 12) begin
        check("offset", 32'(word_offset), 32'(c - 5));
        check("wdata", 32'(data_array_wdata), 32'h0000A000 + 32'(c - 5));
      end
      check("tag", 32'(write_tag_array), 32'(c == 12));
      if (c == 1) begin
        if (hold) miss_address = next_addr;
        else      miss_detected = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0;
      ha[i] = 16'h0000;
    end

    // Reset, then idle with spurious returns
    tick();
    check_quiet("rst1");
    tick();
    check_quiet("rst2");
    rst = 1'b0;
    tick();
    check_quiet("idle");
    spur_v = 1'b1;
    spur_d = 16'h5555;
    #1;
    check("idle_spur_wr", 32'(write_data_array), 0);
    check("idle_spur_wdata", 32'(data_array_wdata), 0);
    check("idle_spur_tag", 32'(write_tag_array), 0);
    spur_v = 1'b0;
    tick();
    check_quiet("idle_after_spur");

    // Basic fill
    run_fill(16'h3A56, 16'h3A50, 1'b0, 16'h0000);
    spur_v = 1'b1;
    spur_d = 16'h1111;
    #1;
    check("post_spur_wr", 32'(write_data_array), 0);
    check("post_spur_tag", 32'(write_tag_array), 0);
    spur_v = 1'b0;
    tick();
    check("post_spur_busy", 32'(fsm_busy), 0);

    // Top-of-memory block
    run_fill(16'hFFFF, 16'hFFF0, 1'b0, 16'h0000);
    tick();

    // Back-to-back: miss held across completion with a new address
    run_fill(16'h2468, 16'h2460, 1'b1, 16'h1234);
    run_fill(16'h1234, 16'h1230, 1'b0, 16'h0000);
    tick();

    // Reset after three words received
    miss_detected = 1'b1;
    miss_address  = 16'h0100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) miss_detected = 1'b0;
      check("abort_tag", 32'(write_tag_array), 0);
    end
    check("abort_wr4", 32'(write_data_array), 1);
    check("abort_off4", 32'(word_offset), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("abort_next");
    for (int c = 0; c < 6; c++) begin
      tick();
      check("abort_idle_wr", 32'(write_data_array), 0);
      check("abort_idle_tag", 32'(write_tag_array), 0);
      check("abort_idle_busy", 32'(fsm_busy), 0);
    end

    // Refill from word 0, then one more fill for the counters
    run_fill(16'h0208, 16'h0200, 1'b0, 16'h0000);
    tick();
    run_fill(16'h7777, 16'h7770, 1'b0, 16'h0000);
`ifdef CACHE_FILL_PERF_EN
    check("fill_count", 32'(fill_count), 2);
    check("fill_cycles", 32'(fill_cycles), 24);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller that sits directly upstream of the cache data and tag arrays.
- On a miss, it fetches one 16-byte block (8 x 16-bit words) from the 4-cycle pipelined main memory.
- It streams each returned word into the data array with a word-offset select, then commits the tag on the final word.
- fsm_busy stalls the pipeline for the duration of the fill.

Parameters:
- WORDS, 8, words per cache block; the counters are $clog2(WORDS) bits wide and the block is 2*WORDS bytes.
- ADDR_W, 16, byte-address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- miss_detected  input  1  cache lookup missed; held high by the requester until fsm_busy falls
- miss_address  input  16  byte address of the missing access
- memory_data_valid  input  1  memory returns one word this cycle, in request order
- memory_data  input  16  returned word
- fsm_busy  output  1  fill in progress; stall requester
- mem_read  output  1  memory read request strobe
- memory_address  output  16  word-aligned request address
- write_data_array  output  1  write enable to the data array
- word_offset  output  3  word index within the block; drives the one-hot block/word decode
- data_array_wdata  output  16  word to write, equal to memory_data
- write_tag_array  output  1  commit the tag and set the valid bit for the block

Behaviour:
- Reset: rst sampled high at posedge. State goes to IDLE, req_cnt=0, rcv_cnt=0, base=0. All outputs are 0 in the following cycle.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy=0, mem_read=0, all write strobes 0.
  - memory_data_valid is ignored.
  - If miss_detected: latch base={miss_address[15:4],4'b0}, clear both counters, go to FILL.
- FILL:
  - fsm_busy=1 throughout.
- Request side:
  - While req_cnt<WORDS: mem_read=1, memory_address=base+2*req_cnt, and req_cnt increments every cycle.
  - When req_cnt==WORDS: mem_read=0 and memory_address holds its last value.
  - One request is issued per cycle with no back-pressure, so all 8 requests occupy 8 consecutive cycles.
- Receive side:
  - Each cycle memory_data_valid=1: write_data_array=1, word_offset=rcv_cnt, data_array_wdata=memory_data, and rcv_cnt increments.
  - write_data_array is combinational with memory_data_valid in the same cycle.
- Completion:
  - On the cycle with memory_data_valid=1 and rcv_cnt==WORDS-1, also assert write_tag_array=1 and go to IDLE.
  - fsm_busy falls the next cycle.
- Latency: miss_detected sampled in cycle 0 gives first request in cycle 1. With memory latency 4, the last word and tag write land in cycle 12 and fsm_busy is low in cycle 13.
- Simultaneous events:
  - Requests and returns overlap freely.
  - A miss_detected still high on the completion cycle is not re-accepted until IDLE is registered (the following cycle).
  - miss_detected that deasserts mid-FILL does not abort; the fill always completes.
- Wrap-around: the address increment is confined to bits [3:1]. base never carries into the tag bits. Counters saturate at WORDS and never wrap within a fill.
- A spurious valid after completion, in IDLE, is dropped. Extra valids beyond WORDS cannot occur in FILL because FILL exits on the 8th.
- Reset mid-FILL: abort immediately. No tag write occurs; any partially written data words remain, but the tag was never validated.

Optional Feature:
- Macro: CACHE_FILL_PERF_EN.
- Defined:
  - Adds output fill_count [15:0], reset to 0, incremented on every write_tag_array pulse, wrapping at 0xFFFF->0.
  - Adds output fill_cycles [15:0], reset to 0, incremented every cycle fsm_busy=1, saturating at 0xFFFF.
- Undefined: neither port nor its registers exist; the remaining behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, no miss.
  - Required response: all outputs 0; memory_data_valid pulses produce no writes.
- Basic fill:
  - Stimulus: miss at 0x3A56; memory model latency 4 returning 0xA000+i.
  - Required response: mem_read for 8 cycles with addresses 0x3A50..0x3A5E step 2. Eight data writes with word_offset 0..7 and data 0xA000..0xA007. write_tag_array only with word 7. fsm_busy high cycles 1-12.
- Top-of-memory block:
  - Stimulus: miss at 0xFFFF.
  - Required response: addresses 0xFFF0..0xFFFE with no carry; fill completes normally.
- Back-to-back misses:
  - Stimulus: miss_detected held high across completion with the address changed to 0x1234.
  - Required response: a new fill starts one cycle after fsm_busy falls, with base 0x1230.
- Reset mid-fill:
  - Stimulus: rst after 3 words are received.
  - Required response: no write_tag_array. Next cycle all outputs are 0. A subsequent miss refills from word 0.
- Perf feature (CACHE_FILL_PERF_EN):
  - Stimulus: two complete fills with latency 4.
  - Required response: fill_count=2 and fill_cycles=24.
